// File: rtl/credential_enroller.sv
`default_nettype none
// ============================================================================
// Module   : credential_enroller (with length_finder and hasher helpers)
// Purpose  : Writable 8-entry credential table {valid, user, hash} with
//            enroll / delete / clear requests and a combinational lookup
//            port matching the fixed CAM+ROM contract used by the verifier.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// length_finder: length of a zero-padded 8-char string = index of the highest
// non-zero byte plus one (byte 0 holds the last character).
// ----------------------------------------------------------------------------
module length_finder (
    input  logic [63:0] str,
    output logic [3:0]  len
);
    // Highest non-zero byte wins because later iterations overwrite.
    always_comb begin
        len = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (str[8*i +: 8] != 8'h00) len = 4'(i + 1);
        end
    end
endmodule

// ----------------------------------------------------------------------------
// hasher: FNV-1a over the first len bytes (byte 0 first), length folded in.
// ----------------------------------------------------------------------------
module hasher (
    input  logic [63:0] data,
    input  logic [3:0]  len,
    output logic [31:0] hash
);
    localparam logic [31:0] c_offset = 32'h811C9DC5;
    localparam logic [31:0] c_prime  = 32'h01000193;

    logic [31:0] w_h;

    // Unrolled FNV-1a; bytes beyond the string length are skipped.
    always_comb begin
        w_h = c_offset;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) w_h = (w_h ^ {24'h0, data[8*i +: 8]}) * c_prime;
        end
        hash = w_h ^ {28'h0, len};
    end
endmodule

// ----------------------------------------------------------------------------
// credential_enroller: top level
// ----------------------------------------------------------------------------
module credential_enroller #(
    parameter int DEPTH  = 8,
    parameter int HASH_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [63:0]       req_user,
    input  logic [63:0]       req_pass,
    output logic              resp_valid,
    output logic [1:0]        resp_status,
    output logic [2:0]        resp_addr,
    input  logic [63:0]       lk_user,
    output logic              lk_hit,
    output logic [2:0]        lk_addr,
    output logic [HASH_W-1:0] lk_hash,
    output logic [3:0]        entry_count
);
    localparam logic [1:0] c_op_enroll = 2'b00;
    localparam logic [1:0] c_op_delete = 2'b01;
    localparam logic [1:0] c_op_clear  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HASH   = 3'd1,
        S_SCAN   = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [63:0]        r_user;
    logic [63:0]        r_pass;
    logic [HASH_W-1:0]  r_hash;
    logic [2:0]         r_idx;
    logic               r_match_found;
    logic [2:0]         r_match_idx;
    logic               r_free_found;
    logic [2:0]         r_free_idx;

    logic [DEPTH-1:0]   r_valid;
    logic [63:0]        r_tbl_user [DEPTH];
    logic [HASH_W-1:0]  r_tbl_hash [DEPTH];

    logic [3:0]         w_user_len;
    logic [3:0]         w_pass_len;
    logic [HASH_W-1:0]  w_hash;
    logic               w_bad;
    logic               w_wr_upd;
    logic               w_wr_new;
    logic               w_del;
    logic               w_clr;

    length_finder u_user_len (.str(r_user), .len(w_user_len));
    length_finder u_pass_len (.str(r_pass), .len(w_pass_len));
    hasher        u_hasher   (.data(r_pass), .len(w_pass_len), .hash(w_hash));

    // Input validation and table-write decode for the COMMIT cycle.
    always_comb begin
        w_bad    = (r_op == 2'b11) ||
                   ((r_op == c_op_enroll) && ((w_user_len == 4'd0) || (w_pass_len == 4'd0))) ||
                   ((r_op == c_op_delete) && (w_user_len == 4'd0));
        w_wr_upd = (r_state == S_COMMIT) && (r_op == c_op_enroll) && r_match_found;
        w_wr_new = (r_state == S_COMMIT) && (r_op == c_op_enroll) && !r_match_found && r_free_found;
        w_del    = (r_state == S_COMMIT) && (r_op == c_op_delete) && r_match_found;
        w_clr    = (r_state == S_COMMIT) && (r_op == c_op_clear);
    end

    // Request FSM, scan bookkeeping, valid bits, count and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_status   <= 2'd0;
            resp_addr     <= 3'd0;
            entry_count   <= 4'd0;
            r_valid       <= '0;
            r_op          <= 2'd0;
            r_user        <= 64'd0;
            r_pass        <= 64'd0;
            r_hash        <= '0;
            r_idx         <= 3'd0;
            r_match_found <= 1'b0;
            r_match_idx   <= 3'd0;
            r_free_found  <= 1'b0;
            r_free_idx    <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_user    <= req_user;
                        r_pass    <= req_pass;
                        req_ready <= 1'b0;
                        r_state   <= (req_op == c_op_clear) ? S_COMMIT : S_HASH;
                    end
                end
                S_HASH: begin
                    r_hash        <= w_hash;
                    r_idx         <= 3'd0;
                    r_match_found <= 1'b0;
                    r_match_idx   <= 3'd0;
                    r_free_found  <= 1'b0;
                    r_free_idx    <= 3'd0;
                    if (w_bad) begin
                        resp_valid  <= 1'b1;
                        resp_status <= 2'd3;
                        resp_addr   <= 3'd0;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Lowest index wins for both the match and the free slot.
                    if (r_valid[r_idx] && (r_tbl_user[r_idx] == r_user) && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!r_valid[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    if (r_idx == 3'd7) r_state <= S_COMMIT;
                    else               r_idx   <= r_idx + 3'd1;
                end
                S_COMMIT: begin
                    resp_valid <= 1'b1;
                    r_state    <= S_RESP;
                    if (w_clr) begin
                        r_valid     <= '0;
                        entry_count <= 4'd0;
                        resp_status <= 2'd0;
                        resp_addr   <= 3'd0;
                    end else if (w_wr_upd) begin
                        resp_status <= 2'd1;
                        resp_addr   <= r_match_idx;
                    end else if (w_wr_new) begin
                        r_valid[r_free_idx] <= 1'b1;
                        entry_count         <= entry_count + 4'd1;
                        resp_status         <= 2'd0;
                        resp_addr           <= r_free_idx;
                    end else if (w_del) begin
                        r_valid[r_match_idx] <= 1'b0;
                        entry_count          <= entry_count - 4'd1;
                        resp_status          <= 2'd0;
                        resp_addr            <= r_match_idx;
                    end else begin
                        // Enroll into a full table, or delete of an unknown user.
                        resp_status <= 2'd2;
                        resp_addr   <= 3'd0;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Table payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_wr_new) begin
            r_tbl_user[r_free_idx] <= r_user;
            r_tbl_hash[r_free_idx] <= r_hash;
        end else if (w_wr_upd) begin
            r_tbl_hash[r_match_idx] <= r_hash;
        end
    end

    // Combinational lookup; descending loop makes the lowest matching slot win.
    always_comb begin
        lk_hit  = 1'b0;
        lk_addr = 3'd0;
        lk_hash = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tbl_user[i] == lk_user)) begin
                lk_hit  = 1'b1;
                lk_addr = 3'(i);
                lk_hash = r_tbl_hash[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_credential_enroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_credential_enroller
// Purpose  : Directed self-checking bench for credential_enroller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_credential_enroller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [63:0] req_user = 64'd0;
    logic [63:0] req_pass = 64'd0;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [2:0]  resp_addr;
    logic [63:0] lk_user = 64'd0;
    logic        lk_hit;
    logic [2:0]  lk_addr;
    logic [31:0] lk_hash;
    logic [3:0]  entry_count;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [63:0] c_alice = 64'h616C696365;
    localparam logic [63:0] c_pass  = 64'h70617373;
    localparam logic [63:0] c_word  = 64'h776F7264;
    localparam logic [63:0] c_zed   = 64'h7A6564;
    localparam logic [63:0] c_bob   = 64'h626F62;
    localparam logic [63:0] c_ghost = 64'h67686F7374;

    credential_enroller #(.DEPTH(8), .HASH_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_user(req_user), .req_pass(req_pass),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_addr(resp_addr),
        .lk_user(lk_user), .lk_hit(lk_hit), .lk_addr(lk_addr), .lk_hash(lk_hash),
        .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    // Reference hash: FNV-1a over the string bytes starting from the last
    // character (byte 0), then xor with the string length.
    function automatic logic [31:0] ref_hash(input logic [63:0] s);
        logic [31:0] h;
        int          n;
        n = 0;
        for (int b = 7; b >= 0; b--) if (n == 0 && s[8*b +: 8] != 8'h00) n = b + 1;
        h = 32'h811C9DC5;
        for (int b = 0; b < n; b++) h = (h ^ {24'h0, s[8*b +: 8]}) * 32'h01000193;
        return h ^ 32'(n);
    endfunction

    function automatic logic [63:0] user_n(input int n);
        return 64'h7573657230 + 64'(n);  // "user1".."user7"
    endfunction

    // Issue one request and wait for its response; lat = edges after accept.
    task automatic do_req(input logic [1:0] op, input logic [63:0] u, input logic [63:0] p,
                          output int lat, output logic [1:0] st, output logic [2:0] ad);
        int w;
        lat = -1; st = 2'd0; ad = 3'd0; w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        req_op = op; req_user = u; req_pass = p; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = n; st = resp_status; ad = resp_addr; break; end
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        lk_user = c_alice; #1;
        tests_run++; if (lk_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_lk_hit got %b want 0", lk_hit); end
        tests_run++; if (lk_addr !== 3'd0) begin tests_failed++; $display("FAIL reset_lk_addr got %0d want 0", lk_addr); end
        tests_run++; if (lk_hash !== 32'd0) begin tests_failed++; $display("FAIL reset_lk_hash got %h want 0", lk_hash); end
        tests_run++; if (entry_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", entry_count); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", req_ready); end
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_enroll();
        int lat; logic [1:0] st; logic [2:0] ad;
        do_req(2'b00, c_alice, c_pass, lat, st, ad);
        tests_run++; if (lat !== 10) begin tests_failed++; $display("FAIL enroll_latency got %0d want 10", lat); end
        tests_run++; if (st !== 2'd0 || ad !== 3'd0) begin tests_failed++; $display("FAIL enroll_resp got st=%0d ad=%0d want 0/0", st, ad); end
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL enroll_ready_during_resp got %b want 0", req_ready); end
        @(posedge clk); #1;
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL enroll_pulse_width got %b want 0", resp_valid); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL enroll_ready_return got %b want 1", req_ready); end
        tests_run++; if (resp_status !== 2'd0) begin tests_failed++; $display("FAIL enroll_status_hold got %0d want 0", resp_status); end
        lk_user = c_alice; #1;
        tests_run++; if (lk_hit !== 1'b1 || lk_addr !== 3'd0) begin tests_failed++; $display("FAIL enroll_lookup got hit=%b addr=%0d want 1/0", lk_hit, lk_addr); end
        tests_run++; if (lk_hash !== ref_hash(c_pass)) begin tests_failed++; $display("FAIL enroll_hash got %h want %h", lk_hash, ref_hash(c_pass)); end
        tests_run++; if (entry_count !== 4'd1) begin tests_failed++; $display("FAIL enroll_count got %0d want 1", entry_count); end
    endtask

    task automatic test_update();
        int lat; logic [1:0] st; logic [2:0] ad;
        do_req(2'b00, c_alice, c_word, lat, st, ad);
        tests_run++; if (lat !== 10 || st !== 2'd1 || ad !== 3'd0) begin tests_failed++; $display("FAIL update_resp got lat=%0d st=%0d ad=%0d want 10/1/0", lat, st, ad); end
        lk_user = c_alice; #1;
        tests_run++; if (lk_hash !== ref_hash(c_word)) begin tests_failed++; $display("FAIL update_hash got %h want %h", lk_hash, ref_hash(c_word)); end
        tests_run++; if (entry_count !== 4'd1) begin tests_failed++; $display("FAIL update_count got %0d want 1", entry_count); end
    endtask

    task automatic test_full();
        int lat; logic [1:0] st; logic [2:0] ad;
        for (int i = 1; i <= 7; i++) begin
            do_req(2'b00, user_n(i), c_pass, lat, st, ad);
            tests_run++; if (st !== 2'd0 || ad !== 3'(i)) begin tests_failed++; $display("FAIL fill_%0d got st=%0d ad=%0d want 0/%0d", i, st, ad, i); end
        end
        tests_run++; if (entry_count !== 4'd8) begin tests_failed++; $display("FAIL fill_count got %0d want 8", entry_count); end
        do_req(2'b00, c_zed, c_pass, lat, st, ad);
        tests_run++; if (lat !== 10 || st !== 2'd2 || ad !== 3'd0) begin tests_failed++; $display("FAIL full_resp got lat=%0d st=%0d ad=%0d want 10/2/0", lat, st, ad); end
        lk_user = c_zed; #1;
        tests_run++; if (lk_hit !== 1'b0 || entry_count !== 4'd8) begin tests_failed++; $display("FAIL full_nochange got hit=%b cnt=%0d want 0/8", lk_hit, entry_count); end
        lk_user = user_n(3); #1;
        tests_run++; if (lk_hit !== 1'b1 || lk_addr !== 3'd3) begin tests_failed++; $display("FAIL pre_delete_lookup got hit=%b addr=%0d want 1/3", lk_hit, lk_addr); end
        do_req(2'b01, user_n(3), 64'd0, lat, st, ad);
        tests_run++; if (st !== 2'd0 || ad !== 3'd3) begin tests_failed++; $display("FAIL delete_resp got st=%0d ad=%0d want 0/3", st, ad); end
        tests_run++; if (lk_hit !== 1'b0 || entry_count !== 4'd7) begin tests_failed++; $display("FAIL delete_effect got hit=%b cnt=%0d want 0/7", lk_hit, entry_count); end
        do_req(2'b00, c_zed, c_pass, lat, st, ad);
        tests_run++; if (st !== 2'd0 || ad !== 3'd3) begin tests_failed++; $display("FAIL refill_resp got st=%0d ad=%0d want 0/3", st, ad); end
        lk_user = c_zed; #1;
        tests_run++; if (lk_hit !== 1'b1 || lk_addr !== 3'd3 || entry_count !== 4'd8) begin tests_failed++; $display("FAIL refill_lookup got hit=%b addr=%0d cnt=%0d want 1/3/8", lk_hit, lk_addr, entry_count); end
    endtask

    task automatic test_bad_input();
        int lat; logic [1:0] st; logic [2:0] ad;
        do_req(2'b00, 64'd0, c_pass, lat, st, ad);
        tests_run++; if (lat !== 1 || st !== 2'd3 || ad !== 3'd0) begin tests_failed++; $display("FAIL bad_user got lat=%0d st=%0d ad=%0d want 1/3/0", lat, st, ad); end
        do_req(2'b00, c_bob, 64'd0, lat, st, ad);
        tests_run++; if (lat !== 1 || st !== 2'd3) begin tests_failed++; $display("FAIL bad_pass got lat=%0d st=%0d want 1/3", lat, st); end
        do_req(2'b11, c_bob, c_pass, lat, st, ad);
        tests_run++; if (lat !== 1 || st !== 2'd3) begin tests_failed++; $display("FAIL bad_op got lat=%0d st=%0d want 1/3", lat, st); end
        tests_run++; if (entry_count !== 4'd8) begin tests_failed++; $display("FAIL bad_nowrite got cnt=%0d want 8", entry_count); end
        do_req(2'b01, c_ghost, 64'd0, lat, st, ad);
        tests_run++; if (lat !== 10 || st !== 2'd2 || ad !== 3'd0) begin tests_failed++; $display("FAIL delete_unknown got lat=%0d st=%0d ad=%0d want 10/2/0", lat, st, ad); end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        apply_reset();
        @(negedge clk);
        req_op = 2'b00; req_user = c_bob; req_pass = c_pass; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        lk_user = c_bob; #1;
        tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_outputs got rdy=%b rv=%b want 1/0", req_ready, resp_valid); end
        tests_run++; if (entry_count !== 4'd0 || lk_hit !== 1'b0) begin tests_failed++; $display("FAIL midreset_table got cnt=%0d hit=%b want 0/0", entry_count, lk_hit); end
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        tests_run++; if (seen !== 1'b0 || lk_hit !== 1'b0) begin tests_failed++; $display("FAIL midreset_dropped got resp=%b hit=%b want 0/0", seen, lk_hit); end
    endtask

    task automatic test_clear();
        int lat; logic [1:0] st; logic [2:0] ad;
        do_req(2'b00, c_alice, c_pass, lat, st, ad);
        for (int i = 1; i <= 4; i++) do_req(2'b00, user_n(i), c_word, lat, st, ad);
        tests_run++; if (entry_count !== 4'd5) begin tests_failed++; $display("FAIL clear_pre_count got %0d want 5", entry_count); end
        do_req(2'b10, 64'd0, 64'd0, lat, st, ad);
        tests_run++; if (lat !== 1 || st !== 2'd0 || ad !== 3'd0) begin tests_failed++; $display("FAIL clear_resp got lat=%0d st=%0d ad=%0d want 1/0/0", lat, st, ad); end
        lk_user = user_n(2); #1;
        tests_run++; if (entry_count !== 4'd0 || lk_hit !== 1'b0) begin tests_failed++; $display("FAIL clear_effect got cnt=%0d hit=%b want 0/0", entry_count, lk_hit); end
    endtask

    initial begin
        test_reset();
        test_enroll();
        test_update();
        test_full();
        test_bad_input();
        test_reset_mid_op();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
